// File: rtl/ls_chain_engine.sv
// Streaming latin-square chain engine: folds NSYM symbols through a writable
// quasigroup table, emitting each chain value and the final digest.
module ls_chain_engine #(
    parameter  int SYMW  = 4,
    parameter  int NSYM  = 16,
    localparam int LSLEN = 1 << SYMW,
    localparam int CNTW  = $clog2(NSYM + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tbl_we,
    input  logic [SYMW-1:0] tbl_row,
    input  logic [SYMW-1:0] tbl_col,
    input  logic [SYMW-1:0] tbl_data,
    input  logic            start,
    input  logic            mode,
    input  logic [SYMW-1:0] seed,
    input  logic            abort,
    input  logic            in_valid,
    input  logic [SYMW-1:0] in_sym,
    output logic            in_ready,
    output logic            out_valid,
    output logic [SYMW-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic [SYMW-1:0] digest
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic [SYMW-1:0] tbl [LSLEN][LSLEN];
    logic            mode_q;
    logic [SYMW-1:0] acc;
    logic [CNTW-1:0] count;
    logic [SYMW-1:0] f_val;
    logic            accept;
    logic            out_hs;
    logic            fin;
    logic            at_last;

    assign busy     = (state != IDLE);
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !abort;
    assign out_hs   = out_valid && out_ready;
    assign fin      = (state == DRAIN) && out_hs && out_last && !abort;
    assign at_last  = (count == CNTW'(NSYM - 1));

    // mode 0 uses the symbol as row, mode 1 uses the accumulator as row
    assign f_val = mode_q ? tbl[acc][in_sym] : tbl[in_sym][acc];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int r = 0; r < LSLEN; r++) begin
                for (int c = 0; c < LSLEN; c++) begin
                    tbl[r][c] <= SYMW'((r + c) % LSLEN);
                end
            end
        end else if (tbl_we && state == IDLE && !start) begin
            tbl[tbl_row][tbl_col] <= tbl_data;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (abort) state_nx = IDLE;
                else if (accept && at_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort || fin) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mode_q    <= 1'b0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            digest    <= '0;
        end else begin
            done <= fin;
            if (state == IDLE && start) begin
                mode_q <= mode;
                acc    <= seed;
                count  <= '0;
            end
            // abort wins over a same-cycle acceptance
            if (busy && abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                count     <= '0;
            end else if (accept) begin
                acc       <= f_val;
                out_data  <= f_val;
                out_valid <= 1'b1;
                out_last  <= at_last;
                count     <= count + CNTW'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (fin) digest <= acc;
        end
    end

endmodule

// File: tb/tb_ls_chain_engine.sv
// Self-checking bench for ls_chain_engine: vector table, hand sequences and
// randomized messages against a table-lookup reference model.
module tb_ls_chain_engine;

    typedef logic [3:0] msg_t [16];

    typedef struct {
        bit         we;
        logic [3:0] r;
        logic [3:0] c;
        logic [3:0] d;
        bit         m;
        logic [3:0] sd;
        logic [3:0] sym;
        int         exp_first;
        int         exp_dig;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tbl_we;
    logic [3:0] tbl_row, tbl_col, tbl_data;
    logic       start, mode, abort;
    logic [3:0] seed;
    logic       in_valid, in_ready;
    logic [3:0] in_sym;
    logic       out_valid, out_last, out_ready;
    logic [3:0] out_data;
    logic       busy, done;
    logic [3:0] digest;

    logic [3:0] ml [16][16];
    logic [3:0] mdigest;
    int         tests = 0;
    int         fails = 0;

    ls_chain_engine dut (
        .clk(clk), .rstn(rstn),
        .tbl_we(tbl_we), .tbl_row(tbl_row), .tbl_col(tbl_col),
        .tbl_data(tbl_data),
        .start(start), .mode(mode), .seed(seed), .abort(abort),
        .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done), .digest(digest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                ml[r][c] = 4'((r + c) % 16);
        mdigest = 4'd0;
    endtask

    task automatic write_tbl(input logic [3:0] r, input logic [3:0] c,
                             input logic [3:0] d);
        @(negedge clk);
        tbl_we = 1'b1; tbl_row = r; tbl_col = c; tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
        ml[r][c] = d;
    endtask

    task automatic run_msg(input bit m, input logic [3:0] sd, input msg_t syms,
                           input int pv, input int pr, input int stall_in,
                           input bit wr_in_run, input bit tp_check,
                           output logic [3:0] first);
        logic [3:0] exp [16];
        logic [3:0] a;
        int si, oi, cyc, early, stall;
        a = sd;
        for (int i = 0; i < 16; i++) begin
            a = m ? ml[a][syms[i]] : ml[syms[i]][a];
            exp[i] = a;
        end
        stall = stall_in;
        first = 4'd0;
        @(negedge clk);
        start = 1'b1; mode = m; seed = sd; in_valid = 1'b0;
        tbl_we = wr_in_run; tbl_row = 4'd2; tbl_col = 4'd5; tbl_data = 4'd1;
        @(negedge clk);
        start = 1'b0;
        si = 0; oi = 0; cyc = 0; early = 0;
        while (oi < 16 && cyc < 3000) begin
            in_valid  = (si < 16) && ($urandom_range(99) < pv);
            in_sym    = (si < 16) ? syms[si] : 4'd0;
            out_ready = ($urandom_range(99) < pr);
            if (stall > 0 && si == 1) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
            end
            #1;
            if (done) early++;
            if (stall > 0 && si == 1 && out_valid) begin
                chk("hold_data", out_data, exp[0]);
                chk("hold_in_ready", in_ready, 0);
                stall--;
            end
            if (out_valid && out_ready) begin
                chk("chain_value", out_data, exp[oi]);
                chk("out_last", out_last, (oi == 15));
                if (oi == 0) first = out_data;
                oi++;
            end
            if (in_valid && in_ready) si++;
            @(negedge clk);
            cyc++;
        end
        tbl_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("outputs_seen", oi, 16);
        chk("early_done", early, 0);
        if (tp_check) chk("throughput_cycles", cyc, 17);
        mdigest = exp[15];
        chk("done_pulse", done, 1);
        chk("digest", digest, mdigest);
        chk("idle_after", busy, 0);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        vec_t       vecs [5];
        msg_t       msg;
        logic [3:0] first, prev;
        int         dbad;

        vecs[0] = '{0, 0, 0, 0, 0, 4'd3, 4'd1, 4, 3};
        vecs[1] = '{1, 2, 5, 9, 0, 4'd5, 4'd2, 9, -1};
        vecs[2] = '{1, 5, 2, 14, 1, 4'd5, 4'd2, 14, -1};
        vecs[3] = '{0, 0, 0, 0, 0, 4'd5, 4'd2, 9, -1};
        vecs[4] = '{0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0};

        rstn = 1'b1; tbl_we = 1'b0; tbl_row = 0; tbl_col = 0; tbl_data = 0;
        start = 1'b0; mode = 1'b0; seed = 0; abort = 1'b0;
        in_valid = 1'b0; in_sym = 0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digest", digest, 0);
        @(negedge clk);
        rstn = 1'b0;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].we) write_tbl(vecs[v].r, vecs[v].c, vecs[v].d);
            for (int i = 0; i < 16; i++) msg[i] = vecs[v].sym;
            run_msg(vecs[v].m, vecs[v].sd, msg, 100, 100, 0, 0, 1, first);
            chk("vec_first", first, vecs[v].exp_first);
            if (vecs[v].exp_dig >= 0) chk("vec_digest", digest, vecs[v].exp_dig);
        end

        // backpressure on first output, same stream as vector 0
        for (int i = 0; i < 16; i++) msg[i] = 4'd1;
        ml[2][5] = 4'd7;
        write_tbl(2, 5, 7);
        run_msg(0, 4'd3, msg, 100, 100, 4, 0, 0, first);
        chk("bp_first", first, 4);
        chk("bp_digest", digest, 3);

        // abort after five symbols, with a competing valid symbol
        prev = mdigest;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = 4'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sym = 4'($urandom); out_ready = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1; in_valid = 1'b1;
        #1;
        chk("abort_busy_before", busy, 1);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_in_ready", in_ready, 0);
        dbad = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dbad++;
            @(negedge clk);
            #1;
        end
        chk("abort_no_done", dbad, 0);
        chk("abort_digest_kept", digest, prev);
        for (int i = 0; i < 16; i++) msg[i] = 4'd0;
        run_msg(0, 4'd0, msg, 100, 100, 0, 0, 1, first);
        chk("zero_first", first, 0);
        chk("zero_digest", digest, 0);

        for (int t = 0; t < 8; t++) begin
            write_tbl(4'($urandom), 4'($urandom), 4'($urandom));
            for (int i = 0; i < 16; i++) msg[i] = 4'($urandom);
            run_msg(1'($urandom), 4'($urandom), msg, $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(0, 3), 0, 0, first);
        end

        // reset mid-run with a modified table
        write_tbl(2, 5, 9);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sym = 4'd2; out_ready = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rstn = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_digest", digest, 0);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) msg[i] = 4'd2;
        run_msg(0, 4'd5, msg, 100, 100, 0, 1, 1, first);
        chk("rst_table_cyclic", first, 7);
        run_msg(0, 4'd5, msg, 100, 100, 0, 0, 1, first);
        chk("run_write_ignored", first, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ls_chain_engine.md
Name: ls_chain_engine

Overview:
- Streaming latin-square chain engine. It is the parametrised successor of the fixed 16-symbol leader-chain computation used in the AONT path.
- Folds a message of NSYM symbols into a running quasigroup accumulator, one symbol per cycle, and emits every intermediate chain value plus the final digest.
- The latin square is held in a writable on-chip table. Adds a row/column operand mode, valid/ready flow control and abort.
- Sits between the message packer and the AONT block mixer.

Parameters:
- SYMW, 4, symbol width in bits.
- LSLEN, 1<<SYMW, latin-square order (derived; not overridden).
- NSYM, 16, symbols per message (>=1).
- CNTW, $clog2(NSYM+1), symbol counter width (derived).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  asynchronous reset, active-high (1 = reset asserted).
- tbl_we  input  1  table write strobe.
- tbl_row  input  SYMW  table write row.
- tbl_col  input  SYMW  table write column.
- tbl_data  input  SYMW  table write value.
- start  input  1  begin message; sampled only in IDLE.
- mode  input  1  latched at start. 0: acc<=L[sym][acc]. 1: acc<=L[acc][sym].
- seed  input  SYMW  initial accumulator, latched at start.
- abort  input  1  abandon current message.
- in_valid  input  1  input symbol valid.
- in_sym  input  SYMW  input symbol.
- in_ready  output  1  engine accepts a symbol this cycle.
- out_valid  output  1  chain value valid.
- out_data  output  SYMW  chain value.
- out_last  output  1  marks the NSYM-th chain value.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on message completion.
- digest  output  SYMW  final accumulator of the last completed message.

Behaviour:
- Reset (async, rstn=1):
  - state=IDLE; acc, count, out_data, digest = 0.
  - out_valid, out_last, done, in_ready = 0.
  - Table reinitialised to the cyclic square L[r][c]=(r+c) mod LSLEN.
- Table:
  - LSLEN x LSLEN x SYMW register array with one registered write port.
  - Writes take effect only when state==IDLE and start==0. Writes are ignored otherwise, including a write in the same cycle as start.
  - Reads are combinational inside the engine.
  - The engine does not check the latin property.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> latch mode, acc=seed, count=0; go to RUN next cycle.
  - in_ready=0 in IDLE.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Symbol accepted when in_valid && in_ready.
  - On acceptance: acc <= f(acc, in_sym); out_data <= the same value; out_valid <= 1; count <= count+1.
  - out_last <= (count==NSYM-1).
  - Latency: chain value appears on out_data the cycle after acceptance.
  - Acceptance of symbol NSYM -> DRAIN.
- DRAIN:
  - in_ready=0.
  - When the last output handshakes (out_valid && out_ready && out_last): digest <= acc, done=1 for one cycle, return to IDLE.
- Output register:
  - Holds out_data/out_last stable while out_valid && !out_ready.
  - Clears out_valid on handshake when no new symbol is accepted in that cycle.
  - Simultaneous handshake and new acceptance -> out_valid stays 1 with new data (full throughput, one symbol/cycle).
- Abort:
  - abort=1 in RUN or DRAIN -> next cycle IDLE; out_valid, out_last = 0; count = 0.
  - digest unchanged; no done.
  - abort in IDLE has no effect. abort has priority over acceptance in the same cycle.
- start while busy: ignored.
- count wraps never; NSYM=1 goes RUN->DRAIN after one symbol.
- Arithmetic: all values SYMW bits; table indices are the raw symbol values, no modulo needed.

Test Plan:
- Default table, mode=0, seed=3, sixteen symbols of 1, out_ready=1:
  - out_data 4,5,...,15,0,1,2,3 on consecutive cycles; out_last on the 16th value.
  - digest=3; done one cycle after the last handshake.
- Write L[2][5]=9 in IDLE, mode=0, seed=5, first symbol 2 -> first out_data=9.
- Write L[5][2]=14, mode=1, seed=5, first symbol 2 -> first out_data=14.
- Same stimulus with mode=0 -> L[2][5]: 7 under the default table, or 9 if the earlier write is retained.
- out_ready=0 after the first accepted symbol:
  - out_valid=1, out_data held, in_ready=0 until out_ready returns.
  - No symbol lost; sequence identical to the first scenario.
- Abort after 5 symbols:
  - Returns to IDLE, no done, digest keeps its previous value.
  - Next start/seed=0 with all-zero symbols -> every out_data=0, digest=0.
- Assert rstn mid-RUN with a modified table:
  - All outputs 0 immediately; table back to cyclic (L[2][5]=7).
  - Write during RUN ignored (verify with a readback via a mode=0 run).
